// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority encoder / round-robin arbiter.
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : prio_pkg

// File: rtl/prio_search.sv
// Combinational circular search: first set bit of vec scanning start, start+1, ..., wrapping at N-1.
module prio_search #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    int unsigned w_pos;
    logic [W-1:0] w_pos_idx;

    // Rotate by start, take the lowest set bit, map back to an index modulo N.
    always_comb begin
        found     = 1'b0;
        idx       = '0;
        w_pos     = 0;
        w_pos_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = 32'(start) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_pos_idx = W'(w_pos);
            if (!found && vec[w_pos_idx]) begin
                found = 1'b1;
                idx   = w_pos_idx;
            end
        end
    end

endmodule : prio_search

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin selection and a valid/ready output stage.
module prio_encoder_rr #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] code,
    output logic [N-1:0] onehot
);

    import prio_pkg::*;

    logic         r_valid;
    logic [W-1:0] r_code;
    logic [N-1:0] r_onehot;
    logic [W-1:0] r_ptr;

    logic         w_accept;
    logic         w_load;
    logic [W-1:0] w_ptr_next;
    logic [W-1:0] w_start;
    logic         w_found;
    logic [W-1:0] w_idx;

    assign w_accept = r_valid && out_ready;
    assign w_load   = !r_valid || out_ready;

    // The grant completing this edge moves the pointer, and a same-edge load already sees it.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_accept) begin
            w_ptr_next = (32'(r_code) == N - 1) ? '0 : r_code + W'(1);
        end
    end

    assign w_start = (mode == MODE_FIXED) ? '0 : w_ptr_next;

    prio_search #(
        .N(N)
    ) u_search (
        .vec  (req),
        .start(w_start),
        .found(w_found),
        .idx  (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_code   <= '0;
            r_onehot <= '0;
            r_ptr    <= '0;
        end else begin
            r_ptr <= w_ptr_next;
            if (w_load) begin
                if (w_found) begin
                    r_valid  <= 1'b1;
                    r_code   <= w_idx;
                    r_onehot <= N'(1) << w_idx;
                end else begin
                    // Empty request: drop valid, keep the last code so it is never undefined.
                    r_valid  <= 1'b0;
                    r_onehot <= '0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign code      = r_code;
    assign onehot    = r_onehot;

endmodule : prio_encoder_rr
